// File: rtl/dr_pkg.sv
// Shared definitions for the data_route fabric.
// Contents:
//   DR_NARROW_W     width of one input port beat, in bits
//   DR_WIDE_W       width of the fabric word, in bits
//   DR_RATIO        number of narrow beats in one fabric word
//   dr_lane_mask_t  one bit per narrow lane of a fabric word
package dr_pkg;

    localparam int DR_NARROW_W = 128;
    localparam int DR_WIDE_W   = 1536;
    localparam int DR_RATIO    = 12;

    typedef logic [DR_RATIO-1:0] dr_lane_mask_t;

endpackage

// File: rtl/axis_upsize_pack_if.sv
// Stream bundle for axis_upsize_pack: the narrow slave stream and the wide
// master stream.
//
// Handshake: a beat moves on a rising clk edge exactly when tvalid and tready
// are both high. A source holding tvalid high keeps tdata/tkeep/tlast stable
// until that edge. A sink may drive tready independently of tvalid.
//
// Modports:
//   slave  - view of the up-converter (consumes s_axis_*, produces m_axis_*)
//   master - view of the surrounding logic (produces s_axis_*, consumes m_axis_*)
interface axis_upsize_pack_if
    import dr_pkg::*;
#(
    parameter int S_WIDTH = DR_NARROW_W,
    parameter int RATIO   = DR_RATIO
);
    localparam int M_WIDTH = S_WIDTH * RATIO;

    logic [S_WIDTH-1:0] s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tlast;
    logic               s_axis_tready;

    logic [M_WIDTH-1:0] m_axis_tdata;
    logic [RATIO-1:0]   m_axis_tkeep;
    logic               m_axis_tlast;
    logic               m_axis_tvalid;
    logic               m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );

endinterface

// File: rtl/axis_upsize_pack.sv
// AXI-Stream width up-converter. It packs RATIO consecutive narrow beats into
// one wide word, with beat 0 in the least significant lane. When s_axis_tlast
// arrives before the word is full, the partial word is sent at once. The unused
// lanes of that word are zero and m_axis_tkeep flags the lanes that hold data.
// The output is registered. While the sink is ready, the block accepts one
// narrow beat on every cycle.
//
// Ports:
//   clk        single clock; all logic is on the rising edge
//   rst        synchronous, active-high reset
//   bus        axis_upsize_pack_if.slave (narrow s_axis_* in, wide m_axis_* out)
//   o_dbg_cnt  current lane counter (index of the next narrow lane to fill)
module axis_upsize_pack
    import dr_pkg::*;
#(
    parameter  int S_WIDTH = DR_NARROW_W,
    parameter  int RATIO   = DR_RATIO,
    localparam int M_WIDTH = S_WIDTH * RATIO,
    localparam int CNT_W   = $clog2(RATIO)
) (
    input  logic              clk,
    input  logic              rst,
    axis_upsize_pack_if.slave bus,
    output logic [CNT_W-1:0]  o_dbg_cnt
);

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);
    localparam logic [CNT_W:0]   CNT_LIMIT = (CNT_W + 1)'(RATIO);

    logic [M_WIDTH-1:0] r_acc;
    logic [RATIO-1:0]   r_keep;
    logic [CNT_W-1:0]   r_cnt;
    logic [M_WIDTH-1:0] r_m_data;
    logic [RATIO-1:0]   r_m_keep;
    logic               r_m_last;
    logic               r_m_valid;
    // Holds s_axis_tready low during reset. It rises on the first cycle after reset.
    logic               r_in_en;

    logic               w_s_ready;
    logic               w_accept;
    logic               w_wide_xfer;
    logic               w_complete;
    logic [M_WIDTH-1:0] w_acc_merged;
    logic [RATIO-1:0]   w_keep_merged;

    // The input side is ready when the output register is empty, or when the
    // output register is being drained in this same cycle.
    assign w_s_ready   = r_in_en & (~r_m_valid | bus.m_axis_tready);
    assign w_accept    = bus.s_axis_tvalid & w_s_ready;
    assign w_wide_xfer = r_m_valid & bus.m_axis_tready;
    assign w_complete  = (r_cnt == LAST_LANE) | bus.s_axis_tlast;

    // Write-enable for the lane selected by r_cnt. The merged value forms either
    // the next accumulator or, on a completing beat, the outgoing word.
    always_comb begin
        w_acc_merged  = r_acc;
        w_keep_merged = r_keep;
        for (int i = 0; i < RATIO; i++) begin
            if (r_cnt == CNT_W'(i)) begin
                w_acc_merged[i*S_WIDTH +: S_WIDTH] = bus.s_axis_tdata;
                w_keep_merged[i]                   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc     <= '0;
            r_keep    <= '0;
            r_cnt     <= '0;
            r_m_data  <= '0;
            r_m_keep  <= '0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
            r_in_en   <= 1'b0;
        end else begin
            r_in_en <= 1'b1;
            if (w_wide_xfer) begin
                r_m_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_complete) begin
                    // A completing beat loads the output register. This has
                    // priority over the clear above, so words can follow each
                    // other with no gap.
                    r_m_data  <= w_acc_merged;
                    r_m_keep  <= w_keep_merged;
                    r_m_last  <= bus.s_axis_tlast;
                    r_m_valid <= 1'b1;
                    r_acc     <= '0;
                    r_keep    <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc  <= w_acc_merged;
                    r_keep <= w_keep_merged;
                    r_cnt  <= r_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ({1'b0, r_cnt} < CNT_LIMIT);
        end
    end

    assign bus.s_axis_tready = w_s_ready;
    assign bus.m_axis_tdata  = r_m_data;
    assign bus.m_axis_tkeep  = r_m_keep;
    assign bus.m_axis_tlast  = r_m_last;
    assign bus.m_axis_tvalid = r_m_valid;
    assign o_dbg_cnt         = r_cnt;

endmodule

// File: tb/tb_axis_upsize_pack.sv
module tb_axis_upsize_pack;
  import dr_pkg::*;

  localparam int SW = DR_NARROW_W;
  localparam int R  = DR_RATIO;
  localparam int MW = SW * R;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] dbg_cnt;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  axis_upsize_pack_if bus ();

  axis_upsize_pack dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .o_dbg_cnt (dbg_cnt)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int words_seen = 0;
  logic [MW-1:0] exp_q[$];
  dr_lane_mask_t keep_q[$];
  logic last_q[$];

  logic [MW-1:0] m_acc = '0;
  dr_lane_mask_t m_keep = '0;
  int m_cnt = 0;
  logic done5 = 1'b0;

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference packing: a beat fills the next lane. A word closes after the
  // twelfth beat or on tlast.
  task automatic model_beat(input logic [SW-1:0] d, input logic l);
    m_acc[m_cnt*SW +: SW] = d;
    m_keep[m_cnt] = 1'b1;
    if (m_cnt == R - 1 || l) begin
      exp_q.push_back(m_acc);
      keep_q.push_back(m_keep);
      last_q.push_back(l);
      m_acc = '0;
      m_keep = '0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // ---------------- driver tasks (call at a negedge, return at a negedge) ----------------
  task automatic send(input logic [SW-1:0] d, input logic l);
    int guard;
    guard = 0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata = d;
    bus.s_axis_tlast = l;
    while (!bus.s_axis_tready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("send_ready", SW'(bus.s_axis_tready), SW'(1'b1));
    if (bus.s_axis_tready) begin
      model_beat(d, l);
      @(negedge clk);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_s_ready", SW'(bus.s_axis_tready), SW'(1'b0));
    chk("rst_m_valid", SW'(bus.m_axis_tvalid), SW'(1'b0));
    chk("rst_m_data", SW'(|bus.m_axis_tdata), SW'(1'b0));
    chk("rst_m_keep", SW'(bus.m_axis_tkeep), SW'(0));
    chk("rst_m_last", SW'(bus.m_axis_tlast), SW'(1'b0));
    chk("rst_cnt", SW'(dbg_cnt), SW'(0));
    m_acc = '0;
    m_keep = '0;
    m_cnt = 0;
    exp_q.delete();
    keep_q.delete();
    last_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready_after", SW'(bus.s_axis_tready), SW'(1'b1));
  endtask

  // ---------------- output monitor / scoreboard ----------------
  always @(negedge clk) begin
    #2;
    if (!rst && bus.m_axis_tvalid && bus.m_axis_tready) begin
      words_seen++;
      if (exp_q.size() == 0) begin
        chk("extra_word", SW'(exp_q.size()), SW'(1));
      end else begin
        logic [MW-1:0] ew;
        dr_lane_mask_t ek;
        logic el;
        ew = exp_q.pop_front();
        ek = keep_q.pop_front();
        el = last_q.pop_front();
        for (int i = 0; i < R; i++) begin
          chk($sformatf("word%0d_lane%0d", words_seen, i), bus.m_axis_tdata[i*SW +: SW], ew[i*SW +: SW]);
        end
        chk($sformatf("word%0d_keep", words_seen), SW'(bus.m_axis_tkeep), SW'(ek));
        chk($sformatf("word%0d_last", words_seen), SW'(bus.m_axis_tlast), SW'(el));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.s_axis_tdata = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast = 1'b0;
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    do_reset();

    // 1: one full word with tlast, 1-cycle latency
    for (int i = 0; i < R; i++) begin
      send(SW'(i + 1), i == R - 1);
      if (i == R - 2) chk("t1_no_early_valid", SW'(bus.m_axis_tvalid), SW'(1'b0));
    end
    chk("t1_latency_valid", SW'(bus.m_axis_tvalid), SW'(1'b1));
    chk("t1_keep", SW'(bus.m_axis_tkeep), SW'(12'hFFF));
    chk("t1_last", SW'(bus.m_axis_tlast), SW'(1'b1));
    chk("t1_lane11", bus.m_axis_tdata[11*SW +: SW], SW'(12));
    repeat (2) @(negedge clk);

    // 2: 36 back-to-back beats, no tlast
    for (int i = 0; i < 3 * R; i++) begin
      chk("t2_s_ready", SW'(bus.s_axis_tready), SW'(1'b1));
      send(SW'(32'h2000 + i), 1'b0);
      chk($sformatf("t2_valid_beat%0d", i), SW'(bus.m_axis_tvalid), SW'((i % R) == R - 1));
    end
    chk("t2_last", SW'(bus.m_axis_tlast), SW'(1'b0));
    repeat (2) @(negedge clk);

    // 3: partial flush after 5 beats
    for (int i = 0; i < 5; i++) send(SW'(32'hA + i), i == 4);
    chk("t3_valid", SW'(bus.m_axis_tvalid), SW'(1'b1));
    chk("t3_keep", SW'(bus.m_axis_tkeep), SW'(12'h01F));
    chk("t3_last", SW'(bus.m_axis_tlast), SW'(1'b1));
    chk("t3_lane4", bus.m_axis_tdata[4*SW +: SW], SW'(32'hE));
    chk("t3_lane5_zero", bus.m_axis_tdata[5*SW +: SW], SW'(0));
    chk("t3_cnt_restart", SW'(dbg_cnt), SW'(0));
    for (int i = 0; i < R; i++) send(SW'(32'h300 + i), i == R - 1);
    repeat (2) @(negedge clk);

    // 4: output held for 20 cycles
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < R; i++) send(SW'(32'h400 + i), i == R - 1);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata = SW'(32'hDEAD);
    for (int c = 0; c < 20; c++) begin
      chk("t4_s_ready_low", SW'(bus.s_axis_tready), SW'(1'b0));
      chk("t4_valid_hold", SW'(bus.m_axis_tvalid), SW'(1'b1));
      chk("t4_keep_hold", SW'(bus.m_axis_tkeep), SW'(12'hFFF));
      chk("t4_last_hold", SW'(bus.m_axis_tlast), SW'(1'b1));
      chk("t4_lane0_hold", bus.m_axis_tdata[0 +: SW], SW'(32'h400));
      chk("t4_lane11_hold", bus.m_axis_tdata[11*SW +: SW], SW'(32'h40B));
      chk("t4_no_accept", SW'(dbg_cnt), SW'(0));
      @(negedge clk);
    end
    bus.s_axis_tvalid = 1'b0;
    bus.m_axis_tready = 1'b1;
    #1;
    chk("t4_s_ready_release", SW'(bus.s_axis_tready), SW'(1'b1));
    @(negedge clk);
    chk("t4_valid_drop", SW'(bus.m_axis_tvalid), SW'(1'b0));
    @(negedge clk);

    // 5: m_axis_tready toggling under continuous input
    done5 = 1'b0;
    fork
      begin
        for (int i = 0; i < 2 * R; i++) send({$urandom, $urandom, $urandom, $urandom}, 1'b0);
        done5 = 1'b1;
      end
      begin
        int g;
        g = 0;
        while (!done5 && g < 500) begin
          @(posedge clk);
          #1;
          bus.m_axis_tready = ~bus.m_axis_tready;
          g++;
        end
      end
    join
    @(negedge clk);
    bus.m_axis_tready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_all_drained", SW'(exp_q.size()), SW'(0));

    // 6: reset in the middle of a packet
    for (int i = 0; i < 7; i++) send(SW'(32'h5000 + i), 1'b0);
    chk("t6_cnt_mid", SW'(dbg_cnt), SW'(7));
    do_reset();
    chk("t6_valid_after_rst", SW'(bus.m_axis_tvalid), SW'(1'b0));
    for (int i = 0; i < R; i++) send(SW'(32'h600 + i), i == R - 1);
    chk("t6_keep", SW'(bus.m_axis_tkeep), SW'(12'hFFF));
    chk("t6_lane7_clean", bus.m_axis_tdata[7*SW +: SW], SW'(32'h607));

    // drain and final accounting
    for (int g = 0; g < 50 && exp_q.size() != 0; g++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("final_queue_empty", SW'(exp_q.size()), SW'(0));
    chk("final_word_count", SW'(words_seen), SW'(10));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
